lane_striper4: RTL and testbench



---
 rtl/lane_striper4.sv | 92 +++++++++
 tb/tb_lane_striper4.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lane_striper4.sv
// rtl/lane_striper4.sv - PCIe TX byte striper: round-robin bytes onto 4 lanes, PAD-filled flush
module lane_striper4 #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PAD_SYM = 8'hF7
) (
    input  logic              clkf,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic [DATA_W-1:0] lane0_data,
    output logic [DATA_W-1:0] lane1_data,
    output logic [DATA_W-1:0] lane2_data,
    output logic [DATA_W-1:0] lane3_data,
    output logic              lane0_valid,
    output logic              lane1_valid,
    output logic              lane2_valid,
    output logic              lane3_valid,
    output logic [3:0]        pad_mask,
    output logic [1:0]        fill_cnt
);

    logic [DATA_W-1:0] slot_q [4];
    logic [DATA_W-1:0] slot_d [4];
    logic [DATA_W-1:0] lane_q [4];
    logic [DATA_W-1:0] lane_d [4];
    logic [3:0]        valid_q, valid_d;
    logic [3:0]        pad_q, pad_d;
    logic [1:0]        fill_q, fill_d;
    logic [2:0]        eff_cnt;
    logic              complete;
    logic              emit;

    always_comb begin
        // slot_d already includes this cycle's byte, so a set completing or
        // flushing in this cycle is taken straight from it.
        slot_d = slot_q;
        if (in_valid) begin
            slot_d[fill_q] = in_data;
        end
        eff_cnt  = {1'b0, fill_q} + {2'b00, in_valid};
        complete = in_valid && (fill_q == 2'd3);
        emit     = complete || (flush && (eff_cnt != 3'd0));
        fill_d   = emit ? 2'd0 : eff_cnt[1:0];

        lane_d  = lane_q;
        pad_d   = pad_q;
        valid_d = 4'b0000;
        if (emit) begin
            valid_d = 4'b1111;
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < eff_cnt) begin
                    lane_d[i] = slot_d[i];
                    pad_d[i]  = 1'b0;
                end else begin
                    lane_d[i] = PAD_SYM;
                    pad_d[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clkf) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
                lane_q[i] <= '0;
            end
            valid_q <= 4'b0000;
            pad_q   <= 4'b0000;
            fill_q  <= 2'd0;
        end else begin
            slot_q  <= slot_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            pad_q   <= pad_d;
            fill_q  <= fill_d;
        end
    end

    assign lane0_data  = lane_q[0];
    assign lane1_data  = lane_q[1];
    assign lane2_data  = lane_q[2];
    assign lane3_data  = lane_q[3];
    assign lane0_valid = valid_q[0];
    assign lane1_valid = valid_q[1];
    assign lane2_valid = valid_q[2];
    assign lane3_valid = valid_q[3];
    assign pad_mask    = pad_q;
    assign fill_cnt    = fill_q;

endmodule

// File: tb/tb_lane_striper4.sv
// tb/tb_lane_striper4.sv - directed scoreboard bench for lane_striper4
module tb_lane_striper4;

    logic       clkf = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       flush = 1'b0;
    logic [7:0] lane0_data, lane1_data, lane2_data, lane3_data;
    logic       lane0_valid, lane1_valid, lane2_valid, lane3_valid;
    logic [3:0] pad_mask;
    logic [1:0] fill_cnt;

    lane_striper4 dut (
        .clkf(clkf), .reset(reset), .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .lane0_data(lane0_data), .lane1_data(lane1_data),
        .lane2_data(lane2_data), .lane3_data(lane3_data),
        .lane0_valid(lane0_valid), .lane1_valid(lane1_valid),
        .lane2_valid(lane2_valid), .lane3_valid(lane3_valid),
        .pad_mask(pad_mask), .fill_cnt(fill_cnt)
    );

    always #5 clkf = ~clkf;

    typedef struct packed {
        logic [3:0]  pm;
        logic [31:0] d;
    } set_t;

    set_t       expq [$];
    logic [7:0] mbuf [$];
    set_t       last_set;
    int         passed = 0;
    int         total = 0;
    int         emissions = 0;
    logic       mon_en = 1'b0;
    logic       rst_seen = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic set_t mk_set(input int n);
        set_t s;
        for (int i = 0; i < 4; i++) begin
            s.d[8*i +: 8] = (i < n) ? mbuf[i] : 8'hF7;
            s.pm[i]       = (i >= n);
        end
        return s;
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic fl);
        in_valid = v;
        in_data  = d;
        flush    = fl;
        if (v) mbuf.push_back(d);
        if (mbuf.size() == 4 || (fl && mbuf.size() > 0)) begin
            expq.push_back(mk_set(mbuf.size()));
            mbuf.delete();
        end
        @(posedge clkf);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) begin
            @(posedge clkf);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        mbuf.delete();
        repeat (n) begin
            @(posedge clkf);
            #1;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    always @(posedge clkf) rst_seen <= reset;

    // Output monitor: pulses are popped against the scoreboard, idle cycles must hold data.
    always @(negedge clkf) begin
        if (mon_en) begin
            set_t obs;
            obs.d  = {lane3_data, lane2_data, lane1_data, lane0_data};
            obs.pm = pad_mask;
            if (rst_seen) begin
                check("reset_outputs", {obs, lane3_valid, lane2_valid, lane1_valid, lane0_valid}, '0);
                last_set = '0;
            end else if (lane0_valid | lane1_valid | lane2_valid | lane3_valid) begin
                emissions++;
                check("valid_all_lanes", {lane3_valid, lane2_valid, lane1_valid, lane0_valid}, 4'hF);
                if (expq.size() == 0) begin
                    check("unexpected_emission", {obs, 1'b1}, {obs, 1'b0});
                end else begin
                    set_t e;
                    e = expq.pop_front();
                    check("emitted_set", obs, e);
                end
                last_set = obs;
            end else begin
                check("idle_hold", obs, last_set);
            end
        end
    end

    initial begin
        do_reset(2);
        mon_en = 1'b1;
        check("reset_fill_cnt", fill_cnt, 2'd0);
        check("reset_lanes", {lane3_data, lane2_data, lane1_data, lane0_data, pad_mask}, '0);

        drive(1, 8'h11, 0);
        drive(1, 8'h22, 0);
        drive(1, 8'h33, 0);
        check("fill_cnt_3", fill_cnt, 2'd3);
        drive(1, 8'h44, 0);
        check("full_set_latency", {lane3_valid, lane2_valid, lane1_valid, lane0_valid}, 4'hF);
        check("full_set_fill", fill_cnt, 2'd0);
        idle(1);
        check("pulse_one_cycle", {lane3_valid, lane2_valid, lane1_valid, lane0_valid}, 4'h0);
        idle(1);

        for (int i = 1; i <= 12; i++) drive(1, 8'(i), 0);
        idle(3);

        drive(1, 8'h5A, 0);
        drive(1, 8'h5B, 0);
        check("fill_cnt_2", fill_cnt, 2'd2);
        drive(0, 8'h00, 1);
        check("flush_fill_cnt", fill_cnt, 2'd0);
        check("flush_pad_mask", pad_mask, 4'b1100);
        idle(1);
        drive(0, 8'h00, 1);
        idle(2);

        drive(1, 8'hA1, 0);
        drive(1, 8'hA2, 0);
        drive(1, 8'hA3, 0);
        drive(1, 8'hA4, 1);
        idle(2);
        drive(1, 8'hB1, 0);
        drive(1, 8'hB2, 1);
        check("flush_with_byte_fill", fill_cnt, 2'd0);
        idle(2);

        drive(1, 8'hC1, 0);
        drive(1, 8'hC2, 0);
        do_reset(1);
        check("midset_reset_fill", fill_cnt, 2'd0);
        drive(1, 8'hD1, 0);
        drive(1, 8'hD2, 0);
        drive(1, 8'hD3, 0);
        drive(1, 8'hD4, 0);
        idle(3);

        check("scoreboard_drained", expq.size(), 0);
        check("emission_count", emissions, 8);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
